// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: sequencing signals exchanged between the core datapath and pipe_ctrl.
//   Core -> controller : ext_stall, fetch_valid, redirect, load_start
//   Controller -> core : hold, pause, stage_ce, stage_valid, kill,
//                        perf_cycles, perf_retired, perf_stall
//   master modport = controller side, slave modport = core side.
interface pipe_ctrl_if #(
    parameter int STAGES = 3,
    parameter int CNT_W  = 32
);
    logic              ext_stall;
    logic              fetch_valid;
    logic              redirect;
    logic              load_start;
    logic              hold;
    logic              pause;
    logic [STAGES-1:0] stage_ce;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] kill;
    logic [CNT_W-1:0]  perf_cycles;
    logic [CNT_W-1:0]  perf_retired;
    logic [CNT_W-1:0]  perf_stall;

    modport master (
        input  ext_stall, fetch_valid, redirect, load_start,
        output hold, pause, stage_ce, stage_valid, kill,
        output perf_cycles, perf_retired, perf_stall
    );

    modport slave (
        output ext_stall, fetch_valid, redirect, load_start,
        input  hold, pause, stage_ce, stage_valid, kill,
        input  perf_cycles, perf_retired, perf_stall
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the in-order core.
//   Tracks a valid bit per stage and produces the global hold, per-stage clock
//   enables and kill strobes; owns the load-pause FSM and the post-redirect
//   bubble counter.
//   Ports: clk, reset (synchronous, active-high), bus (pipe_ctrl_if.master):
//     ext_stall, fetch_valid, redirect, load_start in;
//     hold, pause, stage_ce, stage_valid, kill, perf_* out.
//   Build option: define PIPE_CTRL_PERF_EN to implement the performance
//   counters; otherwise perf_* are tied to 0 and no counter flops exist.
module pipe_ctrl #(
    parameter int STAGES         = 3,
    parameter int REDIRECT_STAGE = 1,
    parameter int LOAD_LAT       = 1,
    parameter int BUBBLE_CYCLES  = 1,
    parameter int CNT_W          = 32
) (
    input logic         clk,
    input logic         reset,
    pipe_ctrl_if.master bus
);
    localparam int LW = LOAD_LAT > 1 ? $clog2(LOAD_LAT) : 1;
    localparam int BW = BUBBLE_CYCLES > 0 ? $clog2(BUBBLE_CYCLES + 1) : 1;
    localparam logic [LW-1:0] LAT_M1 = LW'(LOAD_LAT > 0 ? LOAD_LAT - 1 : 0);
    localparam logic [BW-1:0] BUB_INIT = BW'(BUBBLE_CYCLES);
    // The stage-0 slot written at the redirect edge is already empty, so the
    // counter only has to cover the remaining BUBBLE_CYCLES-1 slots.
    localparam logic [BW-1:0] BUB_ACC = BW'(BUBBLE_CYCLES > 0 ? BUBBLE_CYCLES - 1 : 0);
    localparam logic [STAGES-1:0] KILL_MASK = STAGES'((1 << REDIRECT_STAGE) - 1);

    typedef enum logic [1:0] {IDLE, PAUSE, DONE} state_t;

    state_t            state, state_nx;
    logic [LW-1:0]     cnt, cnt_nx;
    logic [STAGES-1:0] v, v_nx;
    logic [BW-1:0]     bub_cnt, bub_nx;
    logic              trig, pause, hold, acc;
    logic [STAGES-1:0] kill;

    assign trig = bus.load_start & v[STAGES-1] & (LOAD_LAT != 0);

    // cnt holds the pause cycles still owed, including the current one.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pause    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: if (trig) begin
                    pause    = 1'b1;
                    state_nx = LOAD_LAT == 1 ? DONE : PAUSE;
                    cnt_nx   = LAT_M1;
                end
                PAUSE: begin
                    pause = 1'b1;
                    if (!bus.ext_stall) begin
                        cnt_nx   = cnt - 1'b1;
                        state_nx = cnt == LW'(1) ? DONE : PAUSE;
                    end
                end
                DONE: state_nx = bus.ext_stall ? DONE : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    assign hold = bus.ext_stall | pause;
    assign acc  = bus.redirect & v[REDIRECT_STAGE] & ~hold & ~reset;
    assign kill = acc ? KILL_MASK : '0;

    always_comb begin
        v_nx   = v;
        bub_nx = bub_cnt;
        if (!hold) begin
            v_nx   = {v[STAGES-2:0] & ~kill[STAGES-2:0], bus.fetch_valid & (bub_cnt == '0) & ~acc};
            bub_nx = acc ? BUB_ACC : (bub_cnt != '0 ? bub_cnt - 1'b1 : bub_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            v       <= '0;
            bub_cnt <= BUB_INIT;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            v       <= v_nx;
            bub_cnt <= bub_nx;
        end
    end

    assign bus.hold        = hold;
    assign bus.pause       = pause;
    assign bus.stage_ce    = {STAGES{~hold}};
    assign bus.stage_valid = v;
    assign bus.kill        = kill;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc, ret, stl;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc <= '0;
            ret <= '0;
            stl <= '0;
        end else begin
            cyc <= cyc + CNT_W'(1);
            ret <= ret + CNT_W'(v[STAGES-1] & ~hold);
            stl <= stl + CNT_W'(hold);
        end
    end

    assign bus.perf_cycles  = cyc;
    assign bus.perf_retired = ret;
    assign bus.perf_stall   = stl;
`else
    assign bus.perf_cycles  = '0;
    assign bus.perf_retired = '0;
    assign bus.perf_stall   = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl; two configurations share one
//   stimulus stream and are compared every cycle against a behavioural model.
module tb_pipe_ctrl;
    logic clk = 1'b0, rst = 1'b1, es = 1'b0, fv = 1'b0, rd = 1'b0, ld = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // bub = upcoming edges that force stage 0 empty; prem = pause cycles still
    // owed after the current one; done = the load in the last stage has paused.
    typedef struct {
        logic [7:0] v;
        int         bub, prem;
        bit         done;
        longint     cyc, ret, stl;
    } mdl_t;
    mdl_t ma, mb;

    logic [7:0]  sa_v, sa_k, sb_v;
    logic        sa_p, sa_h, sb_p;
    logic [63:0] sb_cyc, sb_stl;

    pipe_ctrl_if #(.STAGES(3), .CNT_W(32)) ia();
    pipe_ctrl_if #(.STAGES(4), .CNT_W(4))  ib();

    assign ia.ext_stall = es;
    assign ia.fetch_valid = fv;
    assign ia.redirect = rd;
    assign ia.load_start = ld;
    assign ib.ext_stall = es;
    assign ib.fetch_valid = fv;
    assign ib.redirect = rd;
    assign ib.load_start = ld;

    pipe_ctrl dut_a (.clk(clk), .reset(rst), .bus(ia));
    pipe_ctrl #(.STAGES(4), .REDIRECT_STAGE(2), .LOAD_LAT(3), .BUBBLE_CYCLES(2), .CNT_W(4))
        dut_b (.clk(clk), .reset(rst), .bus(ib));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_model(input string n, input int s, input int r, input int lat,
                             input int bub, input int w, inout mdl_t m,
                             input logic [7:0] v, input logic [7:0] k, input logic [7:0] ce,
                             input logic p, input logic h,
                             input logic [63:0] pc, input logic [63:0] pr, input logic [63:0] ps);
        logic [7:0]  nv, ek, ece;
        logic        trig, ep, eh, acc;
        logic [63:0] msk;
        msk  = (64'd1 << w) - 64'd1;
        trig = !rst && lat != 0 && ld && m.v[s-1] && m.prem == 0 && !m.done;
        ep   = !rst && (m.prem > 0 || trig);
        eh   = es || ep;
        acc  = !rst && rd && m.v[r] && !eh;
        ek   = acc ? (8'd1 << r) - 8'd1 : 8'd0;
        ece  = eh ? 8'd0 : (8'd1 << s) - 8'd1;
        check({n, "_valid"}, 64'(v), 64'(m.v));
        check({n, "_pause"}, 64'(p), 64'(ep));
        check({n, "_hold"}, 64'(h), 64'(eh));
        check({n, "_kill"}, 64'(k), 64'(ek));
        check({n, "_ce"}, 64'(ce), 64'(ece));
`ifdef PIPE_CTRL_PERF_EN
        check({n, "_cycles"}, pc, 64'(m.cyc) & msk);
        check({n, "_retired"}, pr, 64'(m.ret) & msk);
        check({n, "_stall"}, ps, 64'(m.stl) & msk);
`else
        check({n, "_cycles"}, pc, 64'd0);
        check({n, "_retired"}, pr, 64'd0);
        check({n, "_stall"}, ps, 64'd0);
`endif
        if (rst) begin
            m = '{v: 8'd0, bub: bub, prem: 0, done: 1'b0, cyc: 0, ret: 0, stl: 0};
        end else begin
            m.cyc++;
            if (eh) m.stl++;
            else if (m.v[s-1]) m.ret++;
            if (trig) begin
                m.prem = lat - 1;
                m.done = lat == 1;
            end else if (m.prem > 0) begin
                if (!es) begin
                    m.prem--;
                    m.done = m.prem == 0;
                end
            end else if (m.done && !eh) begin
                m.done = 1'b0;
            end
            if (!eh) begin
                nv = 8'd0;
                for (int i = 1; i < s; i++) nv[i] = m.v[i-1] & ~ek[i-1];
                nv[0] = fv && m.bub == 0 && !acc;
                m.v   = nv;
                m.bub = acc ? (bub > 0 ? bub - 1 : 0) : (m.bub > 0 ? m.bub - 1 : 0);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sa_v   = 8'(ia.stage_valid);
        sa_k   = 8'(ia.kill);
        sa_p   = ia.pause;
        sa_h   = ia.hold;
        sb_v   = 8'(ib.stage_valid);
        sb_p   = ib.pause;
        sb_cyc = 64'(ib.perf_cycles);
        sb_stl = 64'(ib.perf_stall);
        run_model("a", 3, 1, 1, 1, 32, ma, 8'(ia.stage_valid), 8'(ia.kill), 8'(ia.stage_ce),
                  ia.pause, ia.hold, 64'(ia.perf_cycles), 64'(ia.perf_retired), 64'(ia.perf_stall));
        run_model("b", 4, 2, 3, 2, 4, mb, 8'(ib.stage_valid), 8'(ib.kill), 8'(ib.stage_ce),
                  ib.pause, ib.hold, 64'(ib.perf_cycles), 64'(ib.perf_retired), 64'(ib.perf_stall));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fill [5];
        logic [7:0] redir [4];
        int npause;
        fill  = '{8'd0, 8'd0, 8'd1, 8'd3, 8'd7};
        redir = '{8'd4, 8'd1, 8'd3, 8'd7};
        ma = '{v: 8'd0, bub: 1, prem: 0, done: 1'b0, cyc: 0, ret: 0, stl: 0};
        mb = '{v: 8'd0, bub: 2, prem: 0, done: 1'b0, cyc: 0, ret: 0, stl: 0};
        fv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        es = 1'b1;
        cycle();
        check("reset_hold", 64'(sa_h), 64'd1);
        check("reset_pause", 64'(sa_p), 64'd0);
        check("reset_kill", 64'(sa_k), 64'd0);
        es  = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("fill", 64'(sa_v), 64'(fill[i]));
        end
        rd = 1'b1;
        cycle();
        check("redir_kill", 64'(sa_k), 64'd1);
        check("redir_valid", 64'(sa_v), 64'd7);
        rd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("redir_seq", 64'(sa_v), 64'(redir[i]));
        end
        ld = 1'b1;
        cycle();
        check("load_pause", 64'(sa_p), 64'd1);
        check("load_hold", 64'(sa_h), 64'd1);
        check("load_frozen", 64'(sa_v), 64'd7);
        cycle();
        check("load_done_pause", 64'(sa_p), 64'd0);
        check("load_done_hold", 64'(sa_h), 64'd0);
        ld = 1'b0;
        cycle();
        check("load_no_repause", 64'(sa_p), 64'd0);
        repeat (10) cycle();
        npause = 0;
        ld = 1'b1;
        for (int i = 0; i < 8; i++) begin
            es = i == 2 || i == 3;
            cycle();
            ld = 1'b0;
            if (sb_p) begin
                npause++;
                check("lat3_frozen", 64'(sb_v), 64'd15);
            end
        end
        check("lat3_pause_len", 64'(npause), 64'd5);
        es = 1'b1;
        rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_redir_kill", 64'(sa_k), 64'd0);
            check("stall_redir_valid", 64'(sa_v), 64'd7);
        end
        es = 1'b0;
        cycle();
        check("stall_redir_accept", 64'(sa_k), 64'd1);
        rd  = 1'b0;
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            es = i >= 5 && i < 8;
            cycle();
        end
        es = 1'b0;
        cycle();
`ifdef PIPE_CTRL_PERF_EN
        check("perf_wrap_cycles", sb_cyc, 64'd4);
        check("perf_wrap_stall", sb_stl, 64'd3);
`else
        check("perf_off_cycles", sb_cyc, 64'd0);
        check("perf_off_stall", sb_stl, 64'd0);
`endif
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 199) == 0;
            es  = $urandom_range(0, 3) == 0;
            fv  = $urandom_range(0, 3) != 0;
            rd  = $urandom_range(0, 5) == 0;
            ld  = $urandom_range(0, 4) == 0;
            cycle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
